// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, write-queue entry layout, scheduler states and pixel-to-word map.
package fb_pkg;

  localparam int unsigned GRID_W   = 64;
  localparam int unsigned GRID_H   = 48;
  localparam int unsigned SCR_W    = 640;
  localparam int unsigned SCR_H    = 480;
  localparam int unsigned FB_WORDS = GRID_W * GRID_H;
  localparam int unsigned RGB_W    = 24;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned ENTRY_W  = ADDR_W + RGB_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [RGB_W-1:0]  data;
  } fb_wr_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } fb_state_e;

  // Divisors are elaboration constants, so this folds to fixed logic (no runtime divider).
  function automatic logic [ADDR_W-1:0] fb_map(input logic [COORD_W-1:0] px,
                                               input logic [COORD_W-1:0] py);
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    col = px / COORD_W'(SCR_W / GRID_W);
    row = py / COORD_W'(SCR_H / GRID_H);
    return ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/fb_port_scheduler_if.sv
// Sticker/tile writer request channel into the framebuffer port scheduler.
interface fb_port_scheduler_if;
  import fb_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [RGB_W-1:0]  wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full, pop when empty.
module fb_wr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 39
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = store_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fb_port_scheduler.sv
// Shares the single-port framebuffer RAM between scan-out reads and queued tile writes.
// Define FB_TEAR_FREE_EN to restrict write draining to vertical blanking only.
module fb_port_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        active_pixels,
  input  logic                        frame_done,
  input  logic [COORD_W-1:0]          x,
  input  logic [COORD_W-1:0]          y,
  fb_port_scheduler_if.slave          wr,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [RGB_W-1:0]            mem_data,
  output logic                        mem_wren,
  input  logic [RGB_W-1:0]            mem_q,
  output logic [RGB_W-1:0]            pix_rgb,
  output logic                        pix_valid,
  output logic [$clog2(FIFO_DEPTH):0] queue_level
);

  fb_state_e         state_q, state_d;
  logic              ready_en_q;
  logic [1:0]        act_dly_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RGB_W-1:0]  data_q, data_d;
  logic              wren_q, wren_d;
  logic              blank_open;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  fb_wr_entry_t      head;
  fb_wr_entry_t      entry_in;

  assign entry_in    = '{addr: wr.wr_addr, data: wr.wr_data};
  assign wr.wr_ready = ready_en_q && !fifo_full;
  assign push        = wr.wr_valid && wr.wr_ready;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (entry_in),
    .dout_o  (head),
    .count_o (queue_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef FB_TEAR_FREE_EN
  logic vblank_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblank_q <= 1'b0;
    end else if (frame_done) begin
      vblank_q <= 1'b1;
    end else if (active_pixels && (y == '0)) begin
      vblank_q <= 1'b0;
    end
  end

  assign blank_open = vblank_q && !active_pixels;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
  assign blank_open        = !active_pixels;
`endif

  // The RAM-side registers are loaded from state_d, so a popped entry shows up while state_q is DRAIN.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      S_READ: begin
        if (!active_pixels) state_d = (blank_open && !fifo_empty) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (active_pixels)                  state_d = S_READ;
        else if (!blank_open || fifo_empty) state_d = S_IDLE;
      end
      default: begin
        if (active_pixels)                   state_d = S_READ;
        else if (blank_open && !fifo_empty)  state_d = S_DRAIN;
      end
    endcase

    if (state_d == S_READ) begin
      if ((x < COORD_W'(SCR_W)) && (y < COORD_W'(SCR_H))) addr_d = fb_map(x, y);
    end else if (state_d == S_DRAIN) begin
      pop = 1'b1;
      if (head.addr < ADDR_W'(FB_WORDS)) begin
        wren_d = 1'b1;
        addr_d = head.addr;
        data_d = head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
      act_dly_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      act_dly_q  <= {act_dly_q[0], active_pixels};
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;
  assign pix_valid   = act_dly_q[1];
  assign pix_rgb     = pix_valid ? mem_q : '0;

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Directed bench for fb_port_scheduler with a queue-based reference model and per-cycle compare.
module tb_fb_port_scheduler;

  localparam int unsigned DEPTH = 16;

  typedef struct { logic [14:0] a; logic [23:0] d; } ent_t;
  typedef struct { int unsigned cyc; logic [14:0] a; logic [23:0] d; } wlog_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        active_pixels = 1'b0;
  logic        frame_done = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [14:0] mem_address;
  logic [23:0] mem_data;
  logic        mem_wren;
  logic [23:0] mem_q = '0;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic [4:0]  queue_level;

  fb_port_scheduler_if wr_if();

  fb_port_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .active_pixels (active_pixels),
    .frame_done    (frame_done),
    .x             (x),
    .y             (y),
    .wr            (wr_if),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .mem_wren      (mem_wren),
    .mem_q         (mem_q),
    .pix_rgb       (pix_rgb),
    .pix_valid     (pix_valid),
    .queue_level   (queue_level)
  );

  always #5 clk = ~clk;

  // Environment RAM: registered read, write-first not needed since reads and writes never share a cycle.
  logic [23:0] ram   [32768];
  logic [23:0] m_ram [32768];

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  function automatic logic [23:0] init_word(input int unsigned i);
    return 24'(i * 37 + 32'h005A0000);
  endfunction

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc_n = 0;
  wlog_t       wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model: writes sit in a queue, reads win whenever the display is active.
  ent_t        m_q[$];
  ent_t        m_head;
  logic        m_ready_en, m_vblank, m_blank, m_can_push;
  logic [14:0] m_addr;
  logic [23:0] m_data;
  logic        e_wren, e_rd, e_ready, e_pv1, e_pv2;
  logic [23:0] e_px1, e_px2;
  int          e_level;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ready_en = 1'b0; m_vblank = 1'b0;
      m_addr = '0; m_data = '0;
      e_wren = 1'b0; e_rd = 1'b0; e_ready = 1'b0; e_level = 0;
      e_pv1 = 1'b0; e_pv2 = 1'b0; e_px1 = '0; e_px2 = '0;
    end else begin
      m_can_push = m_ready_en && (m_q.size() < DEPTH);
      m_blank = !active_pixels;
`ifdef FB_TEAR_FREE_EN
      m_blank = m_blank && m_vblank;
      if (frame_done) m_vblank = 1'b1;
      else if (active_pixels && y == 10'd0) m_vblank = 1'b0;
`endif
      e_wren = 1'b0;
      e_rd   = 1'b0;
      e_pv2  = e_pv1;
      e_px2  = e_px1;
      e_pv1  = active_pixels;
      e_px1  = '0;
      if (active_pixels) begin
        if (x < 10'd640 && y < 10'd480) begin
          m_addr = 15'((y / 10) * 64 + x / 10);
          e_rd = 1'b1;
        end
        e_px1 = m_ram[m_addr];
      end else if (m_blank && m_q.size() > 0) begin
        m_head = m_q.pop_front();
        if (m_head.a < 15'd3072) begin
          m_ram[m_head.a] = m_head.d;
          m_addr = m_head.a;
          m_data = m_head.d;
          e_wren = 1'b1;
        end
      end
      if (wr_if.wr_valid && m_can_push) m_q.push_back('{wr_if.wr_addr, wr_if.wr_data});
      m_ready_en = 1'b1;
      e_level = m_q.size();
      e_ready = (m_q.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    chk("wr_ready", 32'(wr_if.wr_ready), 32'(e_ready));
    chk("queue_level", 32'(queue_level), 32'(e_level));
    chk("mem_wren", 32'(mem_wren), 32'(e_wren));
    chk("pix_valid", 32'(pix_valid), 32'(e_pv2));
    chk("pix_rgb", 32'(pix_rgb), e_pv2 ? 32'(e_px2) : 32'd0);
    if (e_wren) begin
      chk("wr_address", 32'(mem_address), 32'(m_addr));
      chk("wr_data", 32'(mem_data), 32'(m_data));
    end
    if (e_rd) chk("rd_address", 32'(mem_address), 32'(m_addr));
    if (mem_wren) wlog.push_back('{cyc_n, mem_address, mem_data});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [14:0] a, input logic [23:0] d);
    int unsigned n;
    n = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    while (!wr_if.wr_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(wr_if.wr_ready), 32'd1);
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n_before;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    for (int unsigned i = 0; i < 32768; i++) begin
      ram[i]   = init_word(i);
      m_ram[i] = init_word(i);
    end
    #1 rst = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    chk("rst_queue_level", 32'(queue_level), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    pulse_frame_done();

    // Blank drain keeps order and data
    wlog.delete();
    push(15'd652, 24'hFFFFFF);
    push(15'd655, 24'hFF6E00);
    ticks(5);
    chk("blank_drain_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("blank_drain_addr0", 32'(wlog[0].a), 32'd652);
      chk("blank_drain_data0", 32'(wlog[0].d), 32'hFFFFFF);
      chk("blank_drain_addr1", 32'(wlog[1].a), 32'd655);
      chk("blank_drain_data1", 32'(wlog[1].d), 32'hFF6E00);
    end
    chk("blank_drain_level", 32'(queue_level), 32'd0);

    // Read mapping: (125,67) -> 6*64+12 = 396
    push(15'd396, 24'h00FF00);
    push(15'd7, 24'h123123);
    ticks(4);
    active_pixels = 1'b1; x = 10'd125; y = 10'd67;
    tick();
    chk("map_address", 32'(mem_address), 32'd396);
    tick();
    chk("map_pix_valid", 32'(pix_valid), 32'd1);
    chk("map_pix_rgb", 32'(pix_rgb), 32'h00FF00);
    x = 10'd700;
    ticks(3);
    chk("oor_x_hold", 32'(mem_address), 32'd396);
    active_pixels = 1'b0; x = '0; y = '0;
    ticks(3);

    // Active priority: fill the queue while reading
    wlog.delete();
    active_pixels = 1'b1; x = '0; y = 10'd1;
    for (int unsigned i = 0; i < DEPTH; i++) push(15'(100 + i), 24'(i * 24'h000111 + 24'h010000));
    chk("full_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    chk("full_level", 32'(queue_level), 32'd16);
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 15'd999; wr_if.wr_data = 24'hDEAD00;
    ticks(2);
    wr_if.wr_valid = 1'b0;
    chk("full_level_hold", 32'(queue_level), 32'd16);
    chk("active_no_wren", 32'(wlog.size()), 32'd0);
    active_pixels = 1'b0;
    ticks(20);
    chk("burst_count", 32'(wlog.size()), 32'd16);
    if (wlog.size() == 16) begin
      for (int unsigned i = 0; i < 16; i++) begin
        chk("burst_addr", 32'(wlog[i].a), 32'(100 + i));
        chk("burst_consec", wlog[i].cyc - wlog[0].cyc, i);
      end
    end
    chk("burst_level", 32'(queue_level), 32'd0);

    // Out-of-range address is dequeued without a write
    wlog.delete();
    push(15'd3072, 24'h123456);
    push(15'd5, 24'hABCDEF);
    ticks(5);
    chk("oor_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      chk("oor_addr", 32'(wlog[0].a), 32'd5);
      chk("oor_data", 32'(wlog[0].d), 32'hABCDEF);
    end

    // Horizontal blanking after the first line of a frame
    active_pixels = 1'b1; x = 10'd3; y = '0;
    ticks(2);
    active_pixels = 1'b0;
    wlog.delete();
    push(15'd20, 24'h0A0B0C);
    push(15'd21, 24'h0D0E0F);
    ticks(4);
`ifdef FB_TEAR_FREE_EN
    chk("hblank_held_level", 32'(queue_level), 32'd2);
    chk("hblank_held_writes", 32'(wlog.size()), 32'd0);
    pulse_frame_done();
    ticks(4);
    chk("vblank_drain_level", 32'(queue_level), 32'd0);
    chk("vblank_drain_writes", 32'(wlog.size()), 32'd2);
`else
    chk("hblank_drain_level", 32'(queue_level), 32'd0);
    chk("hblank_drain_writes", 32'(wlog.size()), 32'd2);
    pulse_frame_done();
`endif

    // Reset in the middle of a drain
    active_pixels = 1'b1; x = '0; y = 10'd5;
    for (int unsigned i = 0; i < 8; i++) push(15'(200 + i), 24'(24'h300000 + i));
    active_pixels = 1'b0;
    ticks(2);
    chk("pre_rst_wren", 32'(mem_wren), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(mem_wren), 32'd0);
    chk("mid_rst_level", 32'(queue_level), 32'd0);
    chk("mid_rst_ready", 32'(wr_if.wr_ready), 32'd0);
    tick();
    chk("mid_rst_wren_next", 32'(mem_wren), 32'd0);
    chk("mid_rst_level_next", 32'(queue_level), 32'd0);
    rst = 1'b1;
    tick();
    chk("after_rst_ready", 32'(wr_if.wr_ready), 32'd1);
    n_before = wlog.size();
    ticks(10);
    chk("no_stale_writes", 32'(wlog.size()), 32'(n_before));
    chk("after_rst_level", 32'(queue_level), 32'd0);

    ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
